pipeline_hazard_controller: RTL and testbench

Central hazard and redirect sequencer for the fetch/decode/execute pipeline. Each cycle it selects the next fetch PC from four sources: reset vector, mispredict correction, resolved `jalr` target or predicted PC. It also generates fetch-stall, decode-flush and execute-bubble controls for load-use, `jalr` and mispredict hazards. It replaces the ad-hoc hiccup logic inside the fetch stage and keeps saturating performance counters for stalls and flushes.

---
 rtl/pipeline_hazard_controller.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard/redirect sequencer: picks the next fetch PC and drives the
// fetch-stall, decode-flush and execute-bubble controls, with perf counters.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   predict_pc              predictor's next PC
//   d_*                     decode-stage instruction info
//   e_*                     execute-stage load info and jalr resolution
//   m_mispredict, m_correct_pc  mispredict pulse and corrected PC
//   next_pc                 fetch PC (combinational)
//   stall_f, flush_d, bubble_e  pipeline controls (combinational)
//   state                   registered FSM state
//   jalr_timeout            sticky error flag
//   stall_cycles, flush_events  saturating perf counters
module pipeline_hazard_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          JALR_TIMEOUT = 15,
  parameter logic [31:0] CNT_MAX      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] predict_pc,
  input  logic        d_valid,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_rs1_used,
  input  logic        d_rs2_used,
  input  logic        d_is_jalr,
  input  logic        e_valid,
  input  logic        e_is_load,
  input  logic [4:0]  e_rd,
  input  logic        e_jalr_resolved,
  input  logic [31:0] e_jalr_target,
  input  logic        m_mispredict,
  input  logic [31:0] m_correct_pc,
  output logic [31:0] next_pc,
  output logic        stall_f,
  output logic        flush_d,
  output logic        bubble_e,
  output logic [1:0]  state,
  output logic        jalr_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    JALR_WAIT  = 2'd2,
    FLUSH      = 2'd3
  } st_t;

  localparam logic [2:0] FLOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WMAX  = 8'(JALR_TIMEOUT);

  st_t        st_q, st_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       tmo_set;
  logic       load_use;

  assign load_use = d_valid && e_valid && e_is_load
                 && (e_rd != 5'd0)
                 && ((d_rs1_used && (d_rs1 == e_rd))
                  || (d_rs2_used && (d_rs2 == e_rd)));

  assign state = st_q;

  always_comb begin
    st_d     = st_q;
    fcnt_d   = fcnt_q;
    wcnt_d   = wcnt_q;
    tmo_set  = 1'b0;
    next_pc  = predict_pc;
    stall_f  = 1'b0;
    flush_d  = 1'b0;
    bubble_e = 1'b0;
    if (reset) begin
      next_pc  = RESET_PC;
      flush_d  = 1'b1;
      bubble_e = 1'b1;
      st_d     = RUN;
      fcnt_d   = 3'd0;
      wcnt_d   = 8'd0;
    end else if (m_mispredict) begin
      next_pc  = m_correct_pc;
      flush_d  = 1'b1;
      bubble_e = 1'b1;
      fcnt_d   = FLOAD;
      wcnt_d   = 8'd0;
      st_d     = FLUSH;
    end else begin
      case (st_q)
        JALR_WAIT: begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          if (e_jalr_resolved) begin
            next_pc = e_jalr_target;
            stall_f = 1'b0;
            st_d    = RUN;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            if (wcnt_d == WMAX) begin
              tmo_set = 1'b1;
              st_d    = RUN;
            end
          end
        end
        FLUSH: begin
          bubble_e = 1'b1;
          // counter holds bubbles still owed after this one
          if (fcnt_q <= 3'd1) st_d = RUN;
          if (fcnt_q != 3'd0) fcnt_d = fcnt_q - 3'd1;
        end
        default: begin
          // LOAD_STALL ignores load_use so a load costs one cycle
          if (load_use && (st_q == RUN)) begin
            stall_f  = 1'b1;
            bubble_e = 1'b1;
            st_d     = LOAD_STALL;
          end else if (d_valid && d_is_jalr) begin
            stall_f = 1'b1;
            wcnt_d  = 8'd0;
            st_d    = JALR_WAIT;
          end else begin
            st_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= RUN;
      fcnt_q       <= 3'd0;
      wcnt_q       <= 8'd0;
      jalr_timeout <= 1'b0;
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      st_q   <= st_d;
      fcnt_q <= fcnt_d;
      wcnt_q <= wcnt_d;
      if (tmo_set) jalr_timeout <= 1'b1;
      if (stall_f && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + 32'd1;
      if (m_mispredict && (flush_events != CNT_MAX))
        flush_events <= flush_events + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: table vectors,
// directed sequences and a random run against a reference model.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] predict_pc;
  logic        d_valid, d_rs1_used, d_rs2_used, d_is_jalr;
  logic [4:0]  d_rs1, d_rs2, e_rd;
  logic        e_valid, e_is_load, e_jalr_resolved, m_mispredict;
  logic [31:0] e_jalr_target, m_correct_pc;
  logic [31:0] next_pc, stall_cycles, flush_events;
  logic        stall_f, flush_d, bubble_e, jalr_timeout;
  logic [1:0]  state;
  logic [31:0] next_pc2, stall_cycles2, flush_events2;
  logic        stall_f2, flush_d2, bubble_e2, jalr_timeout2;
  logic [1:0]  state2;

  int total = 0;
  int bad = 0;

  localparam int SAT = 20;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset), .predict_pc(predict_pc),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .d_is_jalr(d_is_jalr), .e_valid(e_valid), .e_is_load(e_is_load),
    .e_rd(e_rd), .e_jalr_resolved(e_jalr_resolved),
    .e_jalr_target(e_jalr_target), .m_mispredict(m_mispredict),
    .m_correct_pc(m_correct_pc), .next_pc(next_pc), .stall_f(stall_f),
    .flush_d(flush_d), .bubble_e(bubble_e), .state(state),
    .jalr_timeout(jalr_timeout), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  // small saturation limit so the no-wrap behaviour is reachable
  pipeline_hazard_controller #(.CNT_MAX(32'(SAT))) dut_sat (
    .clk(clk), .reset(reset), .predict_pc(predict_pc),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .d_is_jalr(d_is_jalr), .e_valid(e_valid), .e_is_load(e_is_load),
    .e_rd(e_rd), .e_jalr_resolved(e_jalr_resolved),
    .e_jalr_target(e_jalr_target), .m_mispredict(m_mispredict),
    .m_correct_pc(m_correct_pc), .next_pc(next_pc2), .stall_f(stall_f2),
    .flush_d(flush_d2), .bubble_e(bubble_e2), .state(state2),
    .jalr_timeout(jalr_timeout2), .stall_cycles(stall_cycles2),
    .flush_events(flush_events2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rs1_used = 0; d_rs2_used = 0;
    d_is_jalr = 0; e_valid = 0; e_is_load = 0; e_rd = 0;
    e_jalr_resolved = 0; e_jalr_target = 0;
    m_mispredict = 0; m_correct_pc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  // reference model: pending-work view of the pipeline
  bit     mw;        // waiting for a jalr target
  int     mwn;       // cycles spent waiting
  int     mbl;       // execute bubbles still owed after a redirect
  bit     mls;       // previous cycle was a load-use stall
  bit     mtmo;
  longint mstalls;
  longint mfl;

  function automatic int exp_state();
    if (mw) return 2;
    if (mbl > 0) return 3;
    if (mls) return 1;
    return 0;
  endfunction

  task automatic model_step(output logic [31:0] xpc,
                            output logic xs, xf, xb);
    bit lu;
    xpc = predict_pc; xs = 0; xf = 0; xb = 0;
    lu = d_valid && e_valid && e_is_load && (e_rd != 0)
      && ((d_rs1_used && d_rs1 == e_rd) || (d_rs2_used && d_rs2 == e_rd));
    if (reset) begin
      xpc = 32'h0; xf = 1; xb = 1;
      mw = 0; mwn = 0; mbl = 0; mls = 0; mtmo = 0; mstalls = 0; mfl = 0;
    end else begin
      if (m_mispredict) begin
        xpc = m_correct_pc; xf = 1; xb = 1;
        mw = 0; mwn = 0; mls = 0; mbl = 2 - 1; mfl++;
      end else if (mw) begin
        xs = 1; xf = 1;
        if (e_jalr_resolved) begin
          xpc = e_jalr_target; xs = 0; mw = 0;
        end else begin
          mwn++;
          if (mwn == 15) begin mtmo = 1; mw = 0; end
        end
      end else if (mbl > 0) begin
        xb = 1; mbl--;
      end else if (lu && !mls) begin
        xs = 1; xb = 1; mls = 1;
      end else if (d_valid && d_is_jalr) begin
        xs = 1; mw = 1; mwn = 0; mls = 0;
      end else begin
        mls = 0;
      end
      if (xs) mstalls++;
    end
  endtask

  typedef struct {
    logic       dv;
    logic [4:0] rs1, rs2;
    logic       u1, u2, ev, ld;
    logic [4:0] rd;
    logic       stall;
  } lu_vec_t;

  lu_vec_t vecs [9];

  initial begin
    logic [31:0] xpc;
    logic        xs, xf, xb;
    longint      sat_s, sat_f;

    vecs[0] = '{1, 5, 0, 1, 0, 1, 1, 5, 1};
    vecs[1] = '{1, 0, 0, 1, 1, 1, 1, 0, 0};
    vecs[2] = '{1, 5, 7, 0, 1, 1, 1, 5, 0};
    vecs[3] = '{1, 3, 9, 1, 1, 1, 1, 9, 1};
    vecs[4] = '{1, 5, 0, 1, 0, 1, 0, 5, 0};
    vecs[5] = '{1, 5, 0, 1, 0, 0, 1, 5, 0};
    vecs[6] = '{0, 5, 5, 1, 1, 1, 1, 5, 0};
    vecs[7] = '{1, 2, 31, 1, 0, 1, 1, 31, 0};
    vecs[8] = '{1, 31, 31, 1, 1, 1, 1, 31, 1};

    clear_in();
    reset = 1;
    predict_pc = 32'h4;

    // reset held three cycles
    repeat (3) begin
      tick();
      chk("rst_pc", next_pc, 32'h0);
      chk("rst_flush", 32'(flush_d), 1);
      chk("rst_bubble", 32'(bubble_e), 1);
      chk("rst_stall", 32'(stall_f), 0);
    end
    reset = 0;
    #1;
    chk("post_rst_pc", next_pc, 32'h4);
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_stalls", stall_cycles, 0);
    chk("post_rst_flushes", flush_events, 0);
    chk("post_rst_tmo", 32'(jalr_timeout), 0);

    // load-use decode table, each from a fresh RUN state
    foreach (vecs[i]) begin
      rst_pulse();
      d_valid = vecs[i].dv; d_rs1 = vecs[i].rs1; d_rs2 = vecs[i].rs2;
      d_rs1_used = vecs[i].u1; d_rs2_used = vecs[i].u2;
      e_valid = vecs[i].ev; e_is_load = vecs[i].ld; e_rd = vecs[i].rd;
      #1;
      chk($sformatf("lu_stall[%0d]", i), 32'(stall_f), 32'(vecs[i].stall));
      chk($sformatf("lu_bubble[%0d]", i), 32'(bubble_e), 32'(vecs[i].stall));
      chk($sformatf("lu_flush[%0d]", i), 32'(flush_d), 0);
      clear_in();
    end
    rst_pulse();

    // load-use: exactly one stall cycle
    e_valid = 1; e_is_load = 1; e_rd = 5; d_valid = 1; d_rs1 = 5;
    d_rs1_used = 1;
    #1;
    chk("lu_seq_stall0", 32'(stall_f), 1);
    chk("lu_seq_bubble0", 32'(bubble_e), 1);
    tick();
    chk("lu_seq_state1", 32'(state), 1);
    chk("lu_seq_stall1", 32'(stall_f), 0);
    clear_in();
    tick();
    chk("lu_seq_state2", 32'(state), 0);
    chk("lu_seq_count", stall_cycles, 1);
    e_valid = 1; e_is_load = 1; e_rd = 0; d_valid = 1; d_rs1 = 0;
    d_rs1_used = 1;
    #1;
    chk("lu_x0_stall", 32'(stall_f), 0);
    clear_in();

    // jalr resolved three cycles after decode
    d_valid = 1; d_is_jalr = 1;
    #1;
    chk("jalr_dec_stall", 32'(stall_f), 1);
    chk("jalr_dec_flush", 32'(flush_d), 0);
    tick();
    clear_in();
    #1;
    chk("jalr_w1_state", 32'(state), 2);
    chk("jalr_w1_stall", 32'(stall_f), 1);
    chk("jalr_w1_flush", 32'(flush_d), 1);
    tick();
    chk("jalr_w2_stall", 32'(stall_f), 1);
    tick();
    e_jalr_resolved = 1; e_jalr_target = 32'h200;
    #1;
    chk("jalr_res_pc", next_pc, 32'h200);
    chk("jalr_res_stall", 32'(stall_f), 0);
    chk("jalr_res_flush", 32'(flush_d), 1);
    tick();
    clear_in();
    #1;
    chk("jalr_done_state", 32'(state), 0);
    chk("jalr_stalls", stall_cycles, 4);

    // mispredict beats a same-cycle jalr resolve
    d_valid = 1; d_is_jalr = 1;
    tick();
    clear_in();
    #1;
    chk("mp_wait_state", 32'(state), 2);
    m_mispredict = 1; m_correct_pc = 32'h80;
    e_jalr_resolved = 1; e_jalr_target = 32'h200;
    #1;
    chk("mp_pc", next_pc, 32'h80);
    chk("mp_bubble0", 32'(bubble_e), 1);
    chk("mp_flush0", 32'(flush_d), 1);
    chk("mp_stall0", 32'(stall_f), 0);
    tick();
    clear_in();
    #1;
    chk("mp_state", 32'(state), 3);
    chk("mp_bubble1", 32'(bubble_e), 1);
    chk("mp_events", flush_events, 1);
    tick();
    chk("mp_state_end", 32'(state), 0);
    chk("mp_bubble2", 32'(bubble_e), 0);
    chk("mp_events_end", flush_events, 1);
    chk("mp_stalls", stall_cycles, 5);

    // jalr never resolves
    d_valid = 1; d_is_jalr = 1;
    tick();
    clear_in();
    #1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tmo_wait_state[%0d]", i), 32'(state), 2);
      chk($sformatf("tmo_wait_flag[%0d]", i), 32'(jalr_timeout), 0);
      tick();
    end
    chk("tmo_state", 32'(state), 0);
    chk("tmo_flag", 32'(jalr_timeout), 1);
    chk("tmo_stalls", stall_cycles, 21);
    chk("sat_stalls", stall_cycles2, 32'(SAT));
    chk("sat_flushes", flush_events2, 1);
    repeat (3) tick();
    chk("tmo_sticky", 32'(jalr_timeout), 1);
    chk("sat_hold", stall_cycles2, 32'(SAT));
    rst_pulse();
    chk("tmo_cleared", 32'(jalr_timeout), 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      reset = (i == 0) || ($urandom_range(0, 299) == 0);
      predict_pc = $urandom;
      d_valid = $urandom_range(0, 3) != 0;
      d_rs1 = 5'($urandom_range(0, 3));
      d_rs2 = 5'($urandom_range(0, 3));
      d_rs1_used = $urandom_range(0, 1) == 1;
      d_rs2_used = $urandom_range(0, 1) == 1;
      d_is_jalr = $urandom_range(0, 7) == 0;
      e_valid = $urandom_range(0, 3) != 0;
      e_is_load = $urandom_range(0, 1) == 1;
      e_rd = 5'($urandom_range(0, 3));
      e_jalr_resolved = $urandom_range(0, 9) == 0;
      e_jalr_target = $urandom;
      m_mispredict = $urandom_range(0, 19) == 0;
      m_correct_pc = $urandom;
      #1;
      if (i > 0) begin
        sat_s = (mstalls > SAT) ? SAT : mstalls;
        sat_f = (mfl > SAT) ? SAT : mfl;
        chk("r_state", 32'(state), 32'(exp_state()));
        chk("r_tmo", 32'(jalr_timeout), 32'(mtmo));
        chk("r_stalls", stall_cycles, 32'(mstalls));
        chk("r_flushes", flush_events, 32'(mfl));
        chk("r_sat_stalls", stall_cycles2, 32'(sat_s));
        chk("r_sat_flushes", flush_events2, 32'(sat_f));
      end
      model_step(xpc, xs, xf, xb);
      chk("r_pc", next_pc, xpc);
      chk("r_stall", 32'(stall_f), 32'(xs));
      chk("r_flush", 32'(flush_d), 32'(xf));
      chk("r_bubble", 32'(bubble_e), 32'(xb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
